// File: rtl/lat_cfg_pkg.sv
// Shared types and frame layout for the look-at-table configuration loader.
package lat_cfg_pkg;

    // Loader sequencing states; encoding is visible on the state_dbg port.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } lat_cfg_state_t;

    // Frame layout: jump1..jump5 from the MSB down, clock select in the LSBs.
    localparam int JUMP_W      = 5;
    localparam int N_JUMP      = 5;
    localparam int CLKSEL_W    = 2;
    localparam int FRAME_W_DEF = N_JUMP * JUMP_W + CLKSEL_W;

    // LSB position of jump field idx (1..N_JUMP); jump1 occupies the top bits.
    function automatic int jump_lsb(input int idx);
        return CLKSEL_W + (N_JUMP - idx) * JUMP_W;
    endfunction

endpackage

// File: rtl/lat_cfg_shifter.sv
// Shadow copy of the accepted frame plus the bit counter that walks it
// MSB first. The serial bit is registered so it lines up with ser_en.
module lat_cfg_shifter
    import lat_cfg_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] data,
    input  logic               start,
    input  logic               step,
    output logic               bit_out,
    output logic               last
);

    localparam int CNT_W = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] shadow;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   nxt_idx;

    // Index of the bit that follows the one currently on bit_out.
    assign nxt_idx = TOP_IDX - (cnt + CNT_W'(1));
    assign last    = (cnt == TOP_IDX);

    // Shadow register: captured on accept and kept for every retry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= data;
        end
    end

    // Bit counter and registered serial bit; start presents the MSB, step the next bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            bit_out <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            bit_out <= shadow[TOP_IDX];
        end else if (step) begin
            cnt     <= cnt + CNT_W'(1);
            bit_out <= shadow[nxt_idx];
        end else begin
            bit_out <= 1'b0;
        end
    end

endmodule

// File: rtl/lat_cfg_loader.sv
// Configuration sequencer: accepts one frame from the host, serializes it
// into the SIPO, waits for its finished flag with timeout and retry, and
// holds the table FSM in reset until a frame has loaded successfully.
//
// Host handshake: a frame transfers on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_data is sampled only then. The host keeps
// cfg_valid and cfg_data stable until that edge; cfg_ready never depends
// on cfg_valid combinationally.
module lat_cfg_loader
    import lat_cfg_pkg::*;
#(
    parameter int FRAME_W   = FRAME_W_DEF,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] cfg_data,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               ser_out,
    output logic               ser_en,
    output logic               ser_clr,
    input  logic               load_done,
    output logic               fsm_hold,
    output logic               busy,
    output logic               cfg_ok,
    output logic               cfg_err,
    output logic [1:0]         retries,
    output logic [1:0]         state_dbg
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    lat_cfg_state_t state, next_state;
    logic [TW-1:0]  timer;
    logic           shf_load, shf_start, shf_step, shf_last;
    logic           accept, success, retry, give_up;

    assign state_dbg = state;

    lat_cfg_shifter #(.FRAME_W(FRAME_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (shf_load),
        .data    (cfg_data),
        .start   (shf_start),
        .step    (shf_step),
        .bit_out (ser_out),
        .last    (shf_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle events; load_done only counts in WAIT_DONE.
    always_comb begin
        next_state = state;
        shf_load   = 1'b0;
        shf_start  = 1'b0;
        shf_step   = 1'b0;
        accept     = 1'b0;
        success    = 1'b0;
        retry      = 1'b0;
        give_up    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    accept     = 1'b1;
                    shf_load   = 1'b1;
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                shf_start  = 1'b1;
                next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shf_last) begin
                    next_state = ST_WAIT_DONE;
                end else begin
                    shf_step = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (load_done) begin
                    success    = 1'b1;
                    next_state = ST_IDLE;
                end else if (timer == TIMER_MAX) begin
                    if (retries < RETRY_MAX) begin
                        retry      = 1'b1;
                        next_state = ST_CLEAR;
                    end else begin
                        give_up    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            ser_clr   <= 1'b0;
            ser_en    <= 1'b0;
        end else begin
            cfg_ready <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
            ser_clr   <= (next_state == ST_CLEAR);
            ser_en    <= (next_state == ST_SHIFT);
        end
    end

    // Status flags and retry count; fsm_hold drops only on a successful load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_hold <= 1'b1;
            cfg_ok   <= 1'b0;
            cfg_err  <= 1'b0;
            retries  <= 2'd0;
        end else begin
            if (accept) begin
                fsm_hold <= 1'b1;
                cfg_ok   <= 1'b0;
                cfg_err  <= 1'b0;
                retries  <= 2'd0;
            end
            if (success) begin
                cfg_ok   <= 1'b1;
                fsm_hold <= 1'b0;
            end
            if (retry) begin
                retries <= retries + 2'd1;
            end
            if (give_up) begin
                cfg_err <= 1'b1;
            end
        end
    end

    // WAIT_DONE timer: reloaded on entry, counts only while staying in WAIT_DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == ST_SHIFT && shf_last) begin
            timer <= '0;
        end else if (state == ST_WAIT_DONE && next_state == ST_WAIT_DONE) begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_lat_cfg_loader.sv
// Directed bench for lat_cfg_loader with a small behavioural SIPO responder.
module tb_lat_cfg_loader;

    localparam int FW = 27;
    localparam int TO = 8;
    localparam int MR = 2;

    logic          clk;
    logic          reset;
    logic [FW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ser_out;
    logic          ser_en;
    logic          ser_clr;
    logic          load_done;
    logic          fsm_hold;
    logic          busy;
    logic          cfg_ok;
    logic          cfg_err;
    logic [1:0]    retries;
    logic [1:0]    state_dbg;

    int total;
    int bad;

    // Results collected by the load monitor.
    int            m_cycles;
    int            m_attempts;
    int            m_en;
    int            m_last_en;
    bit            m_timeout;
    logic [FW-1:0] m_stream [4];
    int            m_bits [4];
    int            m_clr_cyc [4];
    int            m_en_first [4];

    lat_cfg_loader #(.FRAME_W(FW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ser_out   (ser_out),
        .ser_en    (ser_en),
        .ser_clr   (ser_clr),
        .load_done (load_done),
        .fsm_hold  (fsm_hold),
        .busy      (busy),
        .cfg_ok    (cfg_ok),
        .cfg_err   (cfg_err),
        .retries   (retries),
        .state_dbg (state_dbg)
    );

    // Clock and global watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Present a frame and wait (bounded) until it is accepted; returns at the
    // falling edge of the first cycle after the accepting edge.
    task automatic send_frame(input logic [FW-1:0] frame, output bit ok);
        ok        = 1'b0;
        cfg_data  = frame;
        cfg_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cfg_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // Follow one load cycle by cycle (c=1 is the cycle after accept), record
    // the serial streams, and play the SIPO: raise load_done done_delay cycles
    // after the last bit of attempt respond_on (0 = never respond).
    task automatic monitor(input int respond_on, input int done_delay, input bit stale,
                           input bit keep_valid, input int change_at,
                           input logic [FW-1:0] change_data);
        int idx;
        m_cycles   = 0;
        m_attempts = 0;
        m_en       = 0;
        m_last_en  = -100;
        m_timeout  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_stream[k]   = '0;
            m_bits[k]     = 0;
            m_clr_cyc[k]  = 0;
            m_en_first[k] = 0;
        end
        for (int c = 1; c <= 400; c++) begin
            if (cfg_ready === 1'b1) begin
                m_cycles  = c;
                m_timeout = 1'b0;
                break;
            end
            if (ser_clr === 1'b1) begin
                if (m_attempts < 4) m_clr_cyc[m_attempts] = c;
                m_attempts++;
            end
            if (ser_en === 1'b1) begin
                m_en++;
                m_last_en = c;
                if (m_attempts >= 1 && m_attempts <= 4) begin
                    idx = m_attempts - 1;
                    if (m_bits[idx] == 0) m_en_first[idx] = c;
                    m_stream[idx] = {m_stream[idx][FW-2:0], ser_out};
                    m_bits[idx]++;
                end
            end
            if (c == 1 && !keep_valid) cfg_valid = 1'b0;
            if (c == change_at) cfg_data = change_data;
            load_done = 1'b0;
            if (stale && ser_en === 1'b1) load_done = 1'b1;
            if (respond_on != 0 && m_attempts == respond_on && m_bits[respond_on-1] == FW &&
                c == m_last_en + done_delay) load_done = 1'b1;
            @(negedge clk);
        end
        load_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        cfg_data  = '0;
        cfg_valid = 1'b0;
        load_done = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cfg_ready !== 1'b1) begin $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); bad++; end
        total++; if (fsm_hold !== 1'b1) begin $display("FAIL reset_fsm_hold: got %b want 1", fsm_hold); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); bad++; end
        total++; if ({ser_en, ser_clr, ser_out} !== 3'b000) begin $display("FAIL reset_serial: got %b want 000", {ser_en, ser_clr, ser_out}); bad++; end
        total++; if ({cfg_ok, cfg_err, retries} !== 4'b0000) begin $display("FAIL reset_flags: got %b want 0000", {cfg_ok, cfg_err, retries}); bad++; end
        total++; if (state_dbg !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", state_dbg); bad++; end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_load();
        bit ok;
        logic [FW-1:0] f = 27'h5A5A5A5;
        send_frame(f, ok);
        total++; if (!ok) begin $display("FAIL single_accept: got no accept want accept"); bad++; end
        monitor(1, 3, 1'b0, 1'b0, 0, '0);
        total++; if (m_timeout) begin $display("FAIL single_budget: got no idle want idle within budget"); bad++; end
        total++; if (m_cycles != 32) begin $display("FAIL single_latency: got %0d want 32", m_cycles); bad++; end
        total++; if (m_attempts != 1) begin $display("FAIL single_attempts: got %0d want 1", m_attempts); bad++; end
        total++; if (m_stream[0] !== f) begin $display("FAIL single_stream: got %h want %h", m_stream[0], f); bad++; end
        total++; if (m_en != 27) begin $display("FAIL single_en_count: got %0d want 27", m_en); bad++; end
        total++; if (m_clr_cyc[0] != 1 || m_en_first[0] != 2) begin $display("FAIL single_timing: got clr=%0d en=%0d want clr=1 en=2", m_clr_cyc[0], m_en_first[0]); bad++; end
        total++; if ({cfg_ok, fsm_hold, retries, cfg_err} !== 5'b10000) begin $display("FAIL single_flags: got ok=%b hold=%b retries=%0d err=%b want ok=1 hold=0 retries=0 err=0", cfg_ok, fsm_hold, retries, cfg_err); bad++; end
        total++; if (busy !== 1'b0 || state_dbg !== 2'd0) begin $display("FAIL single_idle: got busy=%b state=%0d want busy=0 state=0", busy, state_dbg); bad++; end
    endtask

    task automatic test_timeout_retry();
        bit ok;
        logic [FW-1:0] f = 27'h1234567;
        send_frame(f, ok);
        total++; if (!ok) begin $display("FAIL retry_accept: got no accept want accept"); bad++; end
        monitor(2, 3, 1'b0, 1'b0, 0, '0);
        total++; if (m_cycles != 68) begin $display("FAIL retry_latency: got %0d want 68", m_cycles); bad++; end
        total++; if (m_attempts != 2) begin $display("FAIL retry_attempts: got %0d want 2", m_attempts); bad++; end
        total++; if (m_clr_cyc[1] != 37) begin $display("FAIL retry_clr_cycle: got %0d want 37", m_clr_cyc[1]); bad++; end
        total++; if (m_stream[0] !== f || m_stream[1] !== f) begin $display("FAIL retry_streams: got %h,%h want %h", m_stream[0], m_stream[1], f); bad++; end
        total++; if (m_en != 54) begin $display("FAIL retry_en_count: got %0d want 54", m_en); bad++; end
        total++; if (retries !== 2'd1 || cfg_ok !== 1'b1 || fsm_hold !== 1'b0) begin $display("FAIL retry_flags: got retries=%0d ok=%b hold=%b want 1 1 0", retries, cfg_ok, fsm_hold); bad++; end
    endtask

    task automatic test_perm_fail();
        bit ok;
        logic [FW-1:0] f = 27'h4C3B2A1;
        send_frame(f, ok);
        total++; if (!ok) begin $display("FAIL fail_accept: got no accept want accept"); bad++; end
        monitor(0, 0, 1'b0, 1'b0, 0, '0);
        total++; if (m_cycles != 109) begin $display("FAIL fail_latency: got %0d want 109", m_cycles); bad++; end
        total++; if (m_attempts != 3) begin $display("FAIL fail_attempts: got %0d want 3", m_attempts); bad++; end
        total++; if (m_clr_cyc[2] != 73) begin $display("FAIL fail_clr_cycle: got %0d want 73", m_clr_cyc[2]); bad++; end
        total++; if (m_stream[2] !== f || m_en != 81) begin $display("FAIL fail_streams: got %h en=%0d want %h en=81", m_stream[2], m_en, f); bad++; end
        total++; if ({cfg_err, cfg_ok, fsm_hold} !== 3'b101) begin $display("FAIL fail_flags: got err=%b ok=%b hold=%b want 1 0 1", cfg_err, cfg_ok, fsm_hold); bad++; end
        total++; if (retries !== 2'd2 || state_dbg !== 2'd0) begin $display("FAIL fail_end: got retries=%0d state=%0d want 2 0", retries, state_dbg); bad++; end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [FW-1:0] fa = 27'h0F0F0F0;
        logic [FW-1:0] fb = 27'h3C3C3C3;
        send_frame(fa, ok);
        total++; if (!ok) begin $display("FAIL bp_accept: got no accept want accept"); bad++; end
        monitor(1, 3, 1'b0, 1'b1, 10, fb);
        total++; if (m_cycles != 32) begin $display("FAIL bp_first_latency: got %0d want 32", m_cycles); bad++; end
        total++; if (m_stream[0] !== fa) begin $display("FAIL bp_first_stream: got %h want %h", m_stream[0], fa); bad++; end
        monitor(1, 3, 1'b0, 1'b0, 0, '0);
        total++; if (m_clr_cyc[0] != 1) begin $display("FAIL bp_second_accept: got clr at %0d want 1", m_clr_cyc[0]); bad++; end
        total++; if (m_stream[0] !== fb) begin $display("FAIL bp_second_stream: got %h want %h", m_stream[0], fb); bad++; end
        total++; if (m_cycles != 32 || cfg_ok !== 1'b1) begin $display("FAIL bp_second_done: got cycles=%0d ok=%b want 32 1", m_cycles, cfg_ok); bad++; end
    endtask

    task automatic test_stale_done();
        bit ok;
        logic [FW-1:0] f = 27'h2AAAAAA;
        send_frame(f, ok);
        total++; if (!ok) begin $display("FAIL stale_accept: got no accept want accept"); bad++; end
        monitor(1, 5, 1'b1, 1'b0, 0, '0);
        total++; if (m_cycles != 34) begin $display("FAIL stale_latency: got %0d want 34", m_cycles); bad++; end
        total++; if (m_stream[0] !== f || m_attempts != 1) begin $display("FAIL stale_stream: got %h att=%0d want %h att=1", m_stream[0], m_attempts, f); bad++; end
        total++; if (cfg_ok !== 1'b1 || retries !== 2'd0) begin $display("FAIL stale_flags: got ok=%b retries=%0d want 1 0", cfg_ok, retries); bad++; end
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        int bits;
        int extra;
        logic [FW-1:0] f  = 27'h6DB6DB6;
        logic [FW-1:0] f2 = 27'h0123ABC;
        send_frame(f, ok);
        cfg_valid = 1'b0;
        bits = 0;
        for (int i = 0; i < 60; i++) begin
            if (ser_en === 1'b1) bits++;
            if (bits == 10) break;
            @(negedge clk);
        end
        total++; if (bits != 10) begin $display("FAIL rst_reach_bit10: got %0d want 10", bits); bad++; end
        reset = 1'b0;
        #1;
        total++; if ({cfg_ready, fsm_hold, busy} !== 3'b110) begin $display("FAIL rst_async_ctrl: got %b want 110", {cfg_ready, fsm_hold, busy}); bad++; end
        total++; if ({ser_en, ser_clr, ser_out} !== 3'b000) begin $display("FAIL rst_async_serial: got %b want 000", {ser_en, ser_clr, ser_out}); bad++; end
        total++; if ({cfg_ok, cfg_err, retries, state_dbg} !== 6'b000000) begin $display("FAIL rst_async_flags: got %b want 000000", {cfg_ok, cfg_err, retries, state_dbg}); bad++; end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ser_en !== 1'b0 || ser_clr !== 1'b0) extra++;
        end
        total++; if (extra != 0) begin $display("FAIL rst_no_pulses: got %0d want 0", extra); bad++; end
        reset = 1'b1;
        @(negedge clk);
        send_frame(f2, ok);
        total++; if (!ok) begin $display("FAIL rst_reload_accept: got no accept want accept"); bad++; end
        monitor(1, 3, 1'b0, 1'b0, 0, '0);
        total++; if (m_stream[0] !== f2 || m_en != 27) begin $display("FAIL rst_reload_stream: got %h en=%0d want %h en=27", m_stream[0], m_en, f2); bad++; end
        total++; if (cfg_ok !== 1'b1 || fsm_hold !== 1'b0 || m_cycles != 32) begin $display("FAIL rst_reload_done: got ok=%b hold=%b cycles=%0d want 1 0 32", cfg_ok, fsm_hold, m_cycles); bad++; end
    endtask

    // Test sequence and final report.
    initial begin
        total = 0;
        bad   = 0;
        @(negedge clk);
        test_reset();
        test_single_load();
        test_timeout_retry();
        test_perm_fail();
        test_backpressure();
        test_stale_done();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
